mm_port_arbiter: RTL and testbench

Two-master memory-port arbiter between the DMA controller / accelerator and the single core port of the AXI memory-mapped adapter. It arbitrates the read and write channels independently, locks the winning master onto a channel for one full burst, and forwards that master's request and data beats to the core port. Fairness is round-robin per channel.

---
 rtl/mm_arb_pkg.sv | 21 ++
 rtl/mm_grant_fsm.sv | 88 ++++++++
 rtl/mm_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mm_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_arb_pkg.sv
// Shared types for the two-master memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mm_arb_pkg;

    // Per-channel arbitration phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Which master currently owns a channel
    typedef enum logic {
        OWN_DMA  = 1'b0,
        OWN_XCEL = 1'b1
    } owner_t;

    localparam int LEN_W = 32;

endpackage

// File: rtl/mm_grant_fsm.sv
// Per-channel grant FSM: picks an owner, holds it through request and all burst beats.
// Latency: master request seen in IDLE -> REQ next cycle; last beat -> IDLE next cycle.
// Backpressure: beats are counted only on valid&ready, so stalls freeze the counter.
import mm_arb_pkg::*;

module mm_grant_fsm (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             core_req_ready,
    input  logic             beat,
    input  logic [LEN_W-1:0] len,
    output owner_t           owner,
    output arb_state_t       state
);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    // State, owner, priority pointer and burst bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_DMA;
            ptr_q   <= OWN_DMA;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, lock on request handshake, count beats to the last one
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_REQ;
                    if (req0 && req1)
                        owner_d = ptr_q;
                    else if (req1)
                        owner_d = OWN_XCEL;
                    else
                        owner_d = OWN_DMA;
                end
            end
            ST_REQ: begin
                if (core_req_ready) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    // Equality compare: len = all-ones simply means 2^32 beats
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        ptr_d   = (owner_q == OWN_DMA) ? OWN_XCEL : OWN_DMA;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are the registered state and owner; all forwarding muxes key off these
    always_comb begin
        state = state_q;
        owner = owner_q;
    end

endmodule

// File: rtl/mm_port_arbiter.sv
// Two-master (DMA, accelerator) arbiter onto the single adapter core port, read/write independent.
// Latency: request +1 cycle (grant registered); data beats 0 cycles (pure muxing).
// Backpressure: owner's ready/valid pass straight through; non-owner sees valid/ready held at 0.
import mm_arb_pkg::*;

module mm_port_arbiter #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // DMA read
    input  logic                  dma_read_request_valid,
    output logic                  dma_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] dma_read_addr,
    input  logic [31:0]           dma_read_len,
    input  logic [2:0]            dma_read_size,
    input  logic [1:0]            dma_read_burst,
    output logic [AXI_DWIDTH-1:0] dma_read_data,
    output logic                  dma_read_data_valid,
    input  logic                  dma_read_data_ready,
    // DMA write
    input  logic                  dma_write_request_valid,
    output logic                  dma_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] dma_write_addr,
    input  logic [31:0]           dma_write_len,
    input  logic [2:0]            dma_write_size,
    input  logic [1:0]            dma_write_burst,
    input  logic [AXI_DWIDTH-1:0] dma_write_data,
    input  logic                  dma_write_data_valid,
    output logic                  dma_write_data_ready,
    // Accelerator read
    input  logic                  xcel_read_request_valid,
    output logic                  xcel_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] xcel_read_addr,
    input  logic [31:0]           xcel_read_len,
    input  logic [2:0]            xcel_read_size,
    input  logic [1:0]            xcel_read_burst,
    output logic [AXI_DWIDTH-1:0] xcel_read_data,
    output logic                  xcel_read_data_valid,
    input  logic                  xcel_read_data_ready,
    // Accelerator write
    input  logic                  xcel_write_request_valid,
    output logic                  xcel_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] xcel_write_addr,
    input  logic [31:0]           xcel_write_len,
    input  logic [2:0]            xcel_write_size,
    input  logic [1:0]            xcel_write_burst,
    input  logic [AXI_DWIDTH-1:0] xcel_write_data,
    input  logic                  xcel_write_data_valid,
    output logic                  xcel_write_data_ready,
    // Core port read
    output logic                  core_read_request_valid,
    input  logic                  core_read_request_ready,
    output logic [AXI_AWIDTH-1:0] core_read_addr,
    output logic [31:0]           core_read_len,
    output logic [2:0]            core_read_size,
    output logic [1:0]            core_read_burst,
    input  logic [AXI_DWIDTH-1:0] core_read_data,
    input  logic                  core_read_data_valid,
    output logic                  core_read_data_ready,
    // Core port write
    output logic                  core_write_request_valid,
    input  logic                  core_write_request_ready,
    output logic [AXI_AWIDTH-1:0] core_write_addr,
    output logic [31:0]           core_write_len,
    output logic [2:0]            core_write_size,
    output logic [1:0]            core_write_burst,
    output logic [AXI_DWIDTH-1:0] core_write_data,
    output logic                  core_write_data_valid,
    input  logic                  core_write_data_ready
);

    arb_state_t rd_state, wr_state;
    owner_t     rd_owner, wr_owner;
    logic       rd_req_ph, rd_dat_ph, rd_x;
    logic       wr_req_ph, wr_dat_ph, wr_x;

    assign rd_req_ph = (rd_state == ST_REQ);
    assign rd_dat_ph = (rd_state == ST_DATA);
    assign rd_x      = (rd_owner == OWN_XCEL);
    assign wr_req_ph = (wr_state == ST_REQ);
    assign wr_dat_ph = (wr_state == ST_DATA);
    assign wr_x      = (wr_owner == OWN_XCEL);

    mm_grant_fsm u_rd_fsm (
        .clk            (clk),
        .rst            (rst),
        .req0           (dma_read_request_valid),
        .req1           (xcel_read_request_valid),
        .core_req_ready (core_read_request_valid & core_read_request_ready),
        .beat           (core_read_data_valid & core_read_data_ready),
        .len            (rd_x ? xcel_read_len : dma_read_len),
        .owner          (rd_owner),
        .state          (rd_state)
    );

    mm_grant_fsm u_wr_fsm (
        .clk            (clk),
        .rst            (rst),
        .req0           (dma_write_request_valid),
        .req1           (xcel_write_request_valid),
        .core_req_ready (core_write_request_valid & core_write_request_ready),
        .beat           (core_write_data_valid & core_write_data_ready),
        .len            (wr_x ? xcel_write_len : dma_write_len),
        .owner          (wr_owner),
        .state          (wr_state)
    );

    // Read channel: request fields from owner during REQ, return beats to owner during DATA
    always_comb begin
        core_read_request_valid = 1'b0;
        core_read_addr          = '0;
        core_read_len           = '0;
        core_read_size          = '0;
        core_read_burst         = '0;
        if (rd_req_ph) begin
            core_read_request_valid = rd_x ? xcel_read_request_valid : dma_read_request_valid;
            core_read_addr          = rd_x ? xcel_read_addr  : dma_read_addr;
            core_read_len           = rd_x ? xcel_read_len   : dma_read_len;
            core_read_size          = rd_x ? xcel_read_size  : dma_read_size;
            core_read_burst         = rd_x ? xcel_read_burst : dma_read_burst;
        end
        dma_read_request_ready  = rd_req_ph & ~rd_x & core_read_request_ready;
        xcel_read_request_ready = rd_req_ph &  rd_x & core_read_request_ready;
        dma_read_data           = core_read_data;
        xcel_read_data          = core_read_data;
        dma_read_data_valid     = rd_dat_ph & ~rd_x & core_read_data_valid;
        xcel_read_data_valid    = rd_dat_ph &  rd_x & core_read_data_valid;
        core_read_data_ready    = rd_dat_ph & (rd_x ? xcel_read_data_ready : dma_read_data_ready);
    end

    // Write channel: request fields and write beats both come from the owner
    always_comb begin
        core_write_request_valid = 1'b0;
        core_write_addr          = '0;
        core_write_len           = '0;
        core_write_size          = '0;
        core_write_burst         = '0;
        core_write_data          = '0;
        core_write_data_valid    = 1'b0;
        if (wr_req_ph) begin
            core_write_request_valid = wr_x ? xcel_write_request_valid : dma_write_request_valid;
            core_write_addr          = wr_x ? xcel_write_addr  : dma_write_addr;
            core_write_len           = wr_x ? xcel_write_len   : dma_write_len;
            core_write_size          = wr_x ? xcel_write_size  : dma_write_size;
            core_write_burst         = wr_x ? xcel_write_burst : dma_write_burst;
        end
        if (wr_dat_ph) begin
            core_write_data       = wr_x ? xcel_write_data       : dma_write_data;
            core_write_data_valid = wr_x ? xcel_write_data_valid : dma_write_data_valid;
        end
        dma_write_request_ready  = wr_req_ph & ~wr_x & core_write_request_ready;
        xcel_write_request_ready = wr_req_ph &  wr_x & core_write_request_ready;
        dma_write_data_ready     = wr_dat_ph & ~wr_x & core_write_data_ready;
        xcel_write_data_ready    = wr_dat_ph &  wr_x & core_write_data_ready;
    end

endmodule

// File: tb/tb_mm_port_arbiter.sv
import mm_arb_pkg::*;

module tb_mm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_read_request_valid, dma_read_request_ready;
    logic [31:0] dma_read_addr, dma_read_len, dma_read_data;
    logic [2:0]  dma_read_size;
    logic [1:0]  dma_read_burst;
    logic        dma_read_data_valid, dma_read_data_ready;
    logic        dma_write_request_valid, dma_write_request_ready;
    logic [31:0] dma_write_addr, dma_write_len, dma_write_data;
    logic [2:0]  dma_write_size;
    logic [1:0]  dma_write_burst;
    logic        dma_write_data_valid, dma_write_data_ready;
    logic        xcel_read_request_valid, xcel_read_request_ready;
    logic [31:0] xcel_read_addr, xcel_read_len, xcel_read_data;
    logic [2:0]  xcel_read_size;
    logic [1:0]  xcel_read_burst;
    logic        xcel_read_data_valid, xcel_read_data_ready;
    logic        xcel_write_request_valid, xcel_write_request_ready;
    logic [31:0] xcel_write_addr, xcel_write_len, xcel_write_data;
    logic [2:0]  xcel_write_size;
    logic [1:0]  xcel_write_burst;
    logic        xcel_write_data_valid, xcel_write_data_ready;
    logic        core_read_request_valid, core_read_request_ready;
    logic [31:0] core_read_addr, core_read_len, core_read_data;
    logic [2:0]  core_read_size;
    logic [1:0]  core_read_burst;
    logic        core_read_data_valid, core_read_data_ready;
    logic        core_write_request_valid, core_write_request_ready;
    logic [31:0] core_write_addr, core_write_len, core_write_data;
    logic [2:0]  core_write_size;
    logic [1:0]  core_write_burst;
    logic        core_write_data_valid, core_write_data_ready;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mm_port_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .dma_read_request_valid(dma_read_request_valid), .dma_read_request_ready(dma_read_request_ready),
        .dma_read_addr(dma_read_addr), .dma_read_len(dma_read_len),
        .dma_read_size(dma_read_size), .dma_read_burst(dma_read_burst),
        .dma_read_data(dma_read_data), .dma_read_data_valid(dma_read_data_valid),
        .dma_read_data_ready(dma_read_data_ready),
        .dma_write_request_valid(dma_write_request_valid), .dma_write_request_ready(dma_write_request_ready),
        .dma_write_addr(dma_write_addr), .dma_write_len(dma_write_len),
        .dma_write_size(dma_write_size), .dma_write_burst(dma_write_burst),
        .dma_write_data(dma_write_data), .dma_write_data_valid(dma_write_data_valid),
        .dma_write_data_ready(dma_write_data_ready),
        .xcel_read_request_valid(xcel_read_request_valid), .xcel_read_request_ready(xcel_read_request_ready),
        .xcel_read_addr(xcel_read_addr), .xcel_read_len(xcel_read_len),
        .xcel_read_size(xcel_read_size), .xcel_read_burst(xcel_read_burst),
        .xcel_read_data(xcel_read_data), .xcel_read_data_valid(xcel_read_data_valid),
        .xcel_read_data_ready(xcel_read_data_ready),
        .xcel_write_request_valid(xcel_write_request_valid), .xcel_write_request_ready(xcel_write_request_ready),
        .xcel_write_addr(xcel_write_addr), .xcel_write_len(xcel_write_len),
        .xcel_write_size(xcel_write_size), .xcel_write_burst(xcel_write_burst),
        .xcel_write_data(xcel_write_data), .xcel_write_data_valid(xcel_write_data_valid),
        .xcel_write_data_ready(xcel_write_data_ready),
        .core_read_request_valid(core_read_request_valid), .core_read_request_ready(core_read_request_ready),
        .core_read_addr(core_read_addr), .core_read_len(core_read_len),
        .core_read_size(core_read_size), .core_read_burst(core_read_burst),
        .core_read_data(core_read_data), .core_read_data_valid(core_read_data_valid),
        .core_read_data_ready(core_read_data_ready),
        .core_write_request_valid(core_write_request_valid), .core_write_request_ready(core_write_request_ready),
        .core_write_addr(core_write_addr), .core_write_len(core_write_len),
        .core_write_size(core_write_size), .core_write_burst(core_write_burst),
        .core_write_data(core_write_data), .core_write_data_valid(core_write_data_valid),
        .core_write_data_ready(core_write_data_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        dma_read_request_valid = 0;  dma_read_addr = 0;  dma_read_len = 0;  dma_read_size = 3'd2;  dma_read_burst = 2'd1;
        dma_read_data_ready = 0;
        dma_write_request_valid = 0; dma_write_addr = 0; dma_write_len = 0; dma_write_size = 3'd2; dma_write_burst = 2'd1;
        dma_write_data = 0; dma_write_data_valid = 0;
        xcel_read_request_valid = 0;  xcel_read_addr = 0;  xcel_read_len = 0;  xcel_read_size = 3'd2;  xcel_read_burst = 2'd1;
        xcel_read_data_ready = 0;
        xcel_write_request_valid = 0; xcel_write_addr = 0; xcel_write_len = 0; xcel_write_size = 3'd2; xcel_write_burst = 2'd1;
        xcel_write_data = 0; xcel_write_data_valid = 0;
        core_read_request_ready = 0;  core_read_data = 0;  core_read_data_valid = 0;
        core_write_request_ready = 0; core_write_data_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clr_inputs();
        tick();
        tick();
        chk("rst_rd_state", dut.u_rd_fsm.state_q, ST_IDLE);
        chk("rst_wr_state", dut.u_wr_fsm.state_q, ST_IDLE);
        chk("rst_rd_cnt", dut.u_rd_fsm.cnt_q, 0);
        chk("rst_valids", {core_read_request_valid, core_write_request_valid, core_write_data_valid,
                           dma_read_data_valid, xcel_read_data_valid}, 0);
        chk("rst_readies", {dma_read_request_ready, xcel_read_request_ready, dma_write_request_ready,
                            xcel_write_request_ready, core_read_data_ready, dma_write_data_ready,
                            xcel_write_data_ready}, 0);
        chk("rst_fields", {core_read_addr, core_write_addr}, 0);
        chk("rst_wdata", core_write_data, 0);
        rst = 0;
    endtask

    // Complete one read burst for master `who`; its request must already be raised this cycle.
    task automatic rd_xfer(input logic who, input int nbeats, input logic [31:0] addr);
        int w = 0;
        tick();
        while (!core_read_request_valid && w < 8) begin
            tick();
            w++;
        end
        chk("rd_grant_latency", w, 0);
        if (w >= 8) return;
        chk("rd_req_addr", core_read_addr, addr);
        chk("rd_req_len", core_read_len, nbeats - 1);
        core_read_request_ready = 1;
        #1;
        chk("rd_req_rdy_own", who ? xcel_read_request_ready : dma_read_request_ready, 1);
        chk("rd_req_rdy_oth", who ? dma_read_request_ready : xcel_read_request_ready, 0);
        tick();
        core_read_request_ready = 0;
        if (who) xcel_read_request_valid = 0; else dma_read_request_valid = 0;
        dma_read_data_ready = 1;
        xcel_read_data_ready = 1;
        for (int i = 0; i < nbeats; i++) begin
            core_read_data_valid = 1;
            core_read_data = $urandom;
            #1;
            chk("rd_beat_vld_own", who ? xcel_read_data_valid : dma_read_data_valid, 1);
            chk("rd_beat_vld_oth", who ? dma_read_data_valid : xcel_read_data_valid, 0);
            chk("rd_beat_dat", who ? xcel_read_data : dma_read_data, core_read_data);
            chk("rd_beat_rdy", core_read_data_ready, 1);
            tick();
        end
        core_read_data_valid = 0;
        #1;
        chk("rd_end_idle", dut.u_rd_fsm.state_q, ST_IDLE);
        chk("rd_end_noreq", core_read_request_valid, 0);
    endtask

    // Complete one write burst for master `who`; the other master also drives beats to catch misrouting.
    task automatic wr_xfer(input logic who, input int nbeats, input logic [31:0] addr);
        int w = 0;
        logic [31:0] d;
        tick();
        while (!core_write_request_valid && w < 8) begin
            tick();
            w++;
        end
        chk("wr_grant_latency", w, 0);
        if (w >= 8) return;
        chk("wr_req_addr", core_write_addr, addr);
        core_write_request_ready = 1;
        #1;
        chk("wr_req_rdy_own", who ? xcel_write_request_ready : dma_write_request_ready, 1);
        chk("wr_req_rdy_oth", who ? dma_write_request_ready : xcel_write_request_ready, 0);
        tick();
        core_write_request_ready = 0;
        if (who) xcel_write_request_valid = 0; else dma_write_request_valid = 0;
        core_write_data_ready = 1;
        for (int i = 0; i < nbeats; i++) begin
            d = $urandom;
            dma_write_data_valid = 1;  xcel_write_data_valid = 1;
            dma_write_data  = who ? 32'hDEAD_0000 : d;
            xcel_write_data = who ? d : 32'hDEAD_0000;
            #1;
            chk("wr_beat_vld", core_write_data_valid, 1);
            chk("wr_beat_dat", core_write_data, d);
            chk("wr_beat_rdy_own", who ? xcel_write_data_ready : dma_write_data_ready, 1);
            chk("wr_beat_rdy_oth", who ? dma_write_data_ready : xcel_write_data_ready, 0);
            tick();
        end
        dma_write_data_valid = 0;
        xcel_write_data_valid = 0;
        core_write_data_ready = 0;
        #1;
        chk("wr_end_idle", dut.u_wr_fsm.state_q, ST_IDLE);
        chk("wr_end_noreq", core_write_request_valid, 0);
    endtask

    initial begin
        int rd_n, wr_n, cyc;
        logic rd_hs, wr_hs;

        // Single DMA read, len=3
        do_reset();
        dma_read_request_valid = 1; dma_read_addr = 32'h1000; dma_read_len = 3;
        #1;
        chk("t1_same_cycle_noreq", core_read_request_valid, 0);
        rd_xfer(1'b0, 4, 32'h1000);

        // Simultaneous writes from reset: DMA first, xcel request two cycles after DMA's last beat
        do_reset();
        dma_write_request_valid  = 1; dma_write_addr  = 32'hD000; dma_write_len  = 0;
        xcel_write_request_valid = 1; xcel_write_addr = 32'hA000; xcel_write_len = 0;
        wr_xfer(1'b0, 1, 32'hD000);
        wr_xfer(1'b1, 1, 32'hA000);

        // Continuous read contention: strict alternation starting with DMA
        do_reset();
        dma_read_addr = 32'hD100; dma_read_len = 1;
        xcel_read_addr = 32'hA100; xcel_read_len = 1;
        for (int k = 0; k < 6; k++) begin
            dma_read_request_valid = 1;
            xcel_read_request_valid = 1;
            rd_xfer(k[0], 2, k[0] ? 32'hA100 : 32'hD100);
        end

        // Concurrent DMA read and xcel write, len=7 each, random core stalls
        do_reset();
        dma_read_request_valid = 1;   dma_read_addr = 32'h2000;   dma_read_len = 7;
        xcel_write_request_valid = 1; xcel_write_addr = 32'h3000; xcel_write_len = 7;
        rd_n = 0; wr_n = 0; cyc = 0; rd_hs = 0; wr_hs = 0;
        while ((rd_n < 8 || wr_n < 8) && cyc < 300) begin
            tick();
            cyc++;
            if (rd_hs) dma_read_request_valid = 0;
            if (wr_hs) xcel_write_request_valid = 0;
            core_read_request_ready = 1;
            core_write_request_ready = 1;
            core_read_data_valid = (rd_n < 8) && ($urandom_range(0, 1) == 1);
            core_read_data = 32'h500 + rd_n;
            dma_read_data_ready = 1; xcel_read_data_ready = 1;
            xcel_write_data_valid = (wr_n < 8); xcel_write_data = 32'h700 + wr_n;
            dma_write_data_valid = 1;           dma_write_data = 32'hBAD;
            core_write_data_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (xcel_read_data_valid) chk("t4_xcel_rd_vld", xcel_read_data_valid, 0);
            if (dma_write_data_ready) chk("t4_dma_wr_rdy", dma_write_data_ready, 0);
            if (dma_read_request_ready) rd_hs = 1;
            if (xcel_write_request_ready) wr_hs = 1;
            if (dma_read_data_valid && dma_read_data_ready) begin
                chk("t4_rd_dat", dma_read_data, 32'h500 + rd_n);
                rd_n++;
            end
            if (core_write_data_valid && core_write_data_ready) begin
                chk("t4_wr_dat", core_write_data, 32'h700 + wr_n);
                wr_n++;
            end
        end
        tick();
        clr_inputs();
        #1;
        chk("t4_rd_beats", rd_n, 8);
        chk("t4_wr_beats", wr_n, 8);
        chk("t4_rd_idle", dut.u_rd_fsm.state_q, ST_IDLE);
        chk("t4_wr_idle", dut.u_wr_fsm.state_q, ST_IDLE);

        // Owner backpressure mid-burst freezes the counter
        do_reset();
        dma_read_request_valid = 1; dma_read_addr = 32'h4000; dma_read_len = 3;
        tick();
        chk("t5_req_vld", core_read_request_valid, 1);
        core_read_request_ready = 1;
        tick();
        core_read_request_ready = 0; dma_read_request_valid = 0;
        core_read_data_valid = 1; dma_read_data_ready = 1;
        tick();
        tick();
        dma_read_data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_core_rdy_low", core_read_data_ready, 0);
            chk("t5_cnt_frozen", dut.u_rd_fsm.cnt_q, 2);
            tick();
        end
        dma_read_data_ready = 1;
        tick();
        chk("t5_still_data", dut.u_rd_fsm.state_q, ST_DATA);
        tick();
        core_read_data_valid = 0;
        #1;
        chk("t5_idle", dut.u_rd_fsm.state_q, ST_IDLE);

        // Reset during beat 2 of a len=15 burst
        do_reset();
        dma_read_request_valid = 1; dma_read_addr = 32'h5000; dma_read_len = 15;
        tick();
        core_read_request_ready = 1;
        tick();
        core_read_request_ready = 0; dma_read_request_valid = 0;
        core_read_data_valid = 1; dma_read_data_ready = 1;
        tick();
        tick();
        chk("t6_beat2_vld", dma_read_data_valid, 1);
        rst = 1;
        #1;
        chk("t6_rst_vld", {dma_read_data_valid, core_read_request_valid, core_write_data_valid}, 0);
        chk("t6_rst_rdy", {core_read_data_ready, dma_read_request_ready}, 0);
        chk("t6_rst_idle", dut.u_rd_fsm.state_q, ST_IDLE);
        clr_inputs();
        tick();
        rst = 0;
        xcel_read_request_valid = 1; xcel_read_addr = 32'h6000; xcel_read_len = 0;
        rd_xfer(1'b1, 1, 32'h6000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
